mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory/write-back stage directly downstream of the execute stage.
- Takes the execute stage's result, opcode, destination and operand-address fields, and performs the data-memory access for LDW/STR through a req/ack handshake with a multi-cycle data memory.
- Drives the register-file write port, provides a forwarding copy of the write-back, and stalls upstream while a memory access is outstanding.
- Keeps sticky ALU/memory status flags and a retired-instruction counter.

Parameters:
ADDR_W, 5, data-memory word-address width; 4-bit register fields are zero-extended to this width.
TIMEOUT, 15, maximum cycles spent waiting for dmem_ack before the access is aborted; legal range 1..255.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
ex_data  in  32  execute-stage result: ALU/CMP value, LDW immediate, or STR store data
ex_opcode  in  5  opcode, encoded per shared opcode header macros
ex_dest  in  4  destination register (ALU/CMP/LDW) or store word address (STR)
ex_r_a  in  4  load word address for LDW with ex_isimm=0
ex_isimm  in  1  1: LDW takes ex_data as its value, no memory access
ex_overflow  in  1  ALU overflow flag for the instruction
ex_error  in  1  ALU error flag for the instruction
clr_flags  in  1  clears the sticky flags
dmem_req  out  1  memory request
dmem_we  out  1  1 write, 0 read; valid while dmem_req=1
dmem_addr  out  ADDR_W  word address
dmem_wdata  out  32  store data
dmem_ack  in  1  memory completion, one-cycle pulse
dmem_rdata  in  32  load data; valid when dmem_ack=1
stall  out  1  upstream must hold its outputs
wb_en  out  1  register-file write enable
wb_addr  out  4  register-file write address
wb_data  out  32  register-file write data
fwd_valid  out  1  same as wb_en, for the operand-read stage
fwd_addr  out  4  same as wb_addr
fwd_data  out  32  same as wb_data
ovf_flag  out  1  sticky overflow flag
err_flag  out  1  sticky ALU error flag
mem_err  out  1  sticky memory timeout flag
retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset: synchronous, active-high on rst. State goes to IDLE. Every output goes to 0: dmem_*, stall, wb_*, fwd_*, flags, retired. rst during a WAIT aborts the access: dmem_req=0 on the next cycle and no write-back.
- States: IDLE and WAIT. stall is combinational and equals (state==WAIT).
- Instruction capture: inputs are sampled on every rising edge in IDLE. Inputs are ignored in WAIT.
- wb_en is a one-cycle pulse; wb_addr/wb_data hold their last values when wb_en=0. fwd_* mirror wb_* exactly.
- ALU ops (`NOP < op <= `ARSH) and `CMP:
  - After the sampling edge: wb_en=1, wb_addr=ex_dest, wb_data=ex_data. Latency 1.
  - For ALU ops only: ex_overflow=1 sets ovf_flag; ex_error=1 sets err_flag.
- `LDW with ex_isimm=1: wb_data=ex_data, wb_addr=ex_dest. Latency 1. No memory access.
- `LDW with ex_isimm=0:
  - On sampling: go to WAIT with dmem_req=1, dmem_we=0, dmem_addr=zero-extended ex_r_a. The destination is latched.
  - On an edge with dmem_ack=1 in WAIT: wb_en=1, wb_data=dmem_rdata, dmem_req=0, go to IDLE.
- `STR:
  - On sampling: go to WAIT with dmem_req=1, dmem_we=1, dmem_addr=zero-extended ex_dest, dmem_wdata=ex_data.
  - On ack: return to IDLE with no write-back.
- `NOP, `BRQ, `BRG, `BRS and unknown opcodes: no write-back, no memory access, not counted.
- Request signals: dmem_req, dmem_we, dmem_addr and dmem_wdata are registered and held stable for the whole WAIT.
- Timeout:
  - A wait counter clears on entry to WAIT and increments on each edge in WAIT without ack.
  - If no ack is seen on the edge where the counter reaches TIMEOUT: abort. dmem_req=0, mem_err=1, no write-back, not counted, go to IDLE.
  - An ack on that same edge takes priority over the timeout.
- dmem_ack in IDLE is ignored. Ack is only sampled at edges while in WAIT, so the earliest completion is one cycle after dmem_req rises.
- Back-to-back: the edge that leaves WAIT does not sample a new instruction. The next instruction is sampled on the following edge, because stall was high during the completing cycle.
- retired:
  - Increments by 1 in the same cycle wb_en pulses, or on STR completion.
  - Wraps from 2^CNT_W-1 to 0.
- Sticky flags: cleared by clr_flags on the edge. If clr_flags and a set condition occur on the same edge, set wins.

Test Plan:
- ALU add, ex_dest=3, ex_data=42 -> one cycle later wb_en=1, wb_addr=3, wb_data=42, fwd_* equal to wb_*, retired=1, stall=0 throughout.
- LDW isimm=0, ex_r_a=7, ex_dest=2; memory acks 3 cycles after req with rdata=0xDEADBEEF -> dmem_addr=7, dmem_we=0, stall=1 for 3 cycles, then wb_addr=2, wb_data=0xDEADBEEF, retired+1.
- STR ex_dest=9, ex_data=0x55 followed immediately by an ALU op -> dmem_we=1, addr=9, wdata=0x55 held until ack; no wb_en for the store; the ALU op is sampled only after stall drops and writes back correctly.
- LDW with dmem_ack never asserted, TIMEOUT=15 -> dmem_req drops after 15 wait cycles, mem_err=1, no wb_en, retired unchanged; clr_flags pulse -> mem_err=0.
- ALU op with ex_overflow=1, then clr_flags asserted on the same edge as a second overflowing op -> ovf_flag stays 1; a later clr_flags alone -> 0.
- rst asserted in cycle 2 of a load wait -> next cycle dmem_req=0, state IDLE, all outputs 0; a late ack after reset causes no write-back.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: retires ALU/CMP/LDW results, performs LDW/STR data-memory
// accesses over a req/ack handshake with timeout, and keeps sticky flags and a retire count.

`ifndef NOP
`define NOP  5'd0
`endif
`ifndef ADD
`define ADD  5'd1
`endif
`ifndef ARSH
`define ARSH 5'd9
`endif
`ifndef CMP
`define CMP  5'd10
`endif
`ifndef LDW
`define LDW  5'd11
`endif
`ifndef STR
`define STR  5'd12
`endif

module mem_wb_stage #(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ex_data,
    input  logic [4:0]        ex_opcode,
    input  logic [3:0]        ex_dest,
    input  logic [3:0]        ex_r_a,
    input  logic              ex_isimm,
    input  logic              ex_overflow,
    input  logic              ex_error,
    input  logic              clr_flags,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              stall,
    output logic              wb_en,
    output logic [3:0]        wb_addr,
    output logic [31:0]       wb_data,
    output logic              fwd_valid,
    output logic [3:0]        fwd_addr,
    output logic [31:0]       fwd_data,
    output logic              ovf_flag,
    output logic              err_flag,
    output logic              mem_err,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  wait_cnt;
    logic        ld_pending;
    logic [3:0]  ld_dest;

    logic is_alu;
    logic is_cmp;
    logic is_ldw;
    logic is_str;
    logic in_idle;
    logic ack_seen;
    logic timeout_hit;
    logic set_ovf;
    logic set_err;

    assign is_alu  = (ex_opcode > `NOP) && (ex_opcode <= `ARSH);
    assign is_cmp  = (ex_opcode == `CMP);
    assign is_ldw  = (ex_opcode == `LDW);
    assign is_str  = (ex_opcode == `STR);
    assign in_idle = (state == IDLE);

    // Ack wins over timeout when both land on the same edge.
    assign ack_seen    = (state == WAIT) && dmem_ack;
    assign timeout_hit = (state == WAIT) && !dmem_ack && ((wait_cnt + 8'd1) == 8'(TIMEOUT));

    assign set_ovf = in_idle && is_alu && ex_overflow;
    assign set_err = in_idle && is_alu && ex_error;

    assign stall     = (state == WAIT);
    assign fwd_valid = wb_en;
    assign fwd_addr  = wb_addr;
    assign fwd_data  = wb_data;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if ((is_ldw && !ex_isimm) || is_str) state_nx = WAIT;
            WAIT: if (ack_seen || timeout_hit)         state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            wb_en      <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            retired    <= '0;
            wait_cnt   <= '0;
            ld_pending <= 1'b0;
            ld_dest    <= '0;
        end else begin
            wb_en <= 1'b0;
            if (in_idle) begin
                if (is_alu || is_cmp || (is_ldw && ex_isimm)) begin
                    wb_en   <= 1'b1;
                    wb_addr <= ex_dest;
                    wb_data <= ex_data;
                    retired <= retired + CNT_W'(1);
                end else if (is_ldw) begin
                    dmem_req   <= 1'b1;
                    dmem_we    <= 1'b0;
                    dmem_addr  <= ADDR_W'(ex_r_a);
                    ld_pending <= 1'b1;
                    ld_dest    <= ex_dest;
                    wait_cnt   <= '0;
                end else if (is_str) begin
                    dmem_req   <= 1'b1;
                    dmem_we    <= 1'b1;
                    dmem_addr  <= ADDR_W'(ex_dest);
                    dmem_wdata <= ex_data;
                    ld_pending <= 1'b0;
                    wait_cnt   <= '0;
                end
            end else if (ack_seen) begin
                dmem_req <= 1'b0;
                retired  <= retired + CNT_W'(1);
                if (ld_pending) begin
                    wb_en   <= 1'b1;
                    wb_addr <= ld_dest;
                    wb_data <= dmem_rdata;
                end
            end else if (timeout_hit) begin
                dmem_req <= 1'b0;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    // Sticky flags: a set condition on the clearing edge wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_flag <= 1'b0;
            err_flag <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            ovf_flag <= set_ovf     | (ovf_flag & ~clr_flags);
            err_flag <= set_err     | (err_flag & ~clr_flags);
            mem_err  <= timeout_hit | (mem_err  & ~clr_flags);
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vectors, a transaction-level reference model
// checked every cycle, and literal expectations at key points.

module tb_mem_wb_stage;

    localparam int ADDR_W  = 5;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 16;

    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_CMP = 5'd10;
    localparam logic [4:0] OP_LDW = 5'd11;
    localparam logic [4:0] OP_STR = 5'd12;
    localparam logic [4:0] OP_BRQ = 5'd13;
    localparam logic [4:0] OP_BAD = 5'd31;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       ex_data;
    logic [4:0]        ex_opcode;
    logic [3:0]        ex_dest;
    logic [3:0]        ex_r_a;
    logic              ex_isimm;
    logic              ex_overflow;
    logic              ex_error;
    logic              clr_flags;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic              dmem_ack;
    logic [31:0]       dmem_rdata;
    logic              stall;
    logic              wb_en;
    logic [3:0]        wb_addr;
    logic [31:0]       wb_data;
    logic              fwd_valid;
    logic [3:0]        fwd_addr;
    logic [31:0]       fwd_data;
    logic              ovf_flag;
    logic              err_flag;
    logic              mem_err;
    logic [CNT_W-1:0]  retired;

    mem_wb_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ex_data(ex_data), .ex_opcode(ex_opcode), .ex_dest(ex_dest), .ex_r_a(ex_r_a),
        .ex_isimm(ex_isimm), .ex_overflow(ex_overflow), .ex_error(ex_error),
        .clr_flags(clr_flags),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .ovf_flag(ovf_flag), .err_flag(err_flag), .mem_err(mem_err), .retired(retired)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // One outstanding access at most; it either completes on ack or is dropped at TIMEOUT.
    bit          m_busy, m_is_load, m_req, m_we, m_wb_en, m_ovf, m_err, m_merr;
    bit          s_ovf, s_err, s_merr;
    int          m_age;
    logic [3:0]  m_dest, m_wb_addr;
    logic [31:0] m_addr, m_wdata, m_wb_data;
    logic [15:0] m_ret;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_is_load = 0; m_req = 0; m_we = 0; m_wb_en = 0;
            m_ovf = 0; m_err = 0; m_merr = 0; m_age = 0; m_dest = 0;
            m_wb_addr = 0; m_wb_data = 0; m_addr = 0; m_wdata = 0; m_ret = 0;
        end else begin
            s_ovf = 0; s_err = 0; s_merr = 0;
            m_wb_en = 0;
            if (m_busy) begin
                m_age++;
                if (dmem_ack) begin
                    m_busy = 0; m_req = 0; m_ret++;
                    if (m_is_load) begin
                        m_wb_en = 1; m_wb_addr = m_dest; m_wb_data = dmem_rdata;
                    end
                end else if (m_age == TIMEOUT) begin
                    m_busy = 0; m_req = 0; s_merr = 1;
                end
            end else if ((ex_opcode >= 5'd1 && ex_opcode <= 5'd9) || ex_opcode == OP_CMP
                         || (ex_opcode == OP_LDW && ex_isimm)) begin
                m_wb_en = 1; m_wb_addr = ex_dest; m_wb_data = ex_data; m_ret++;
                if (ex_opcode != OP_CMP && ex_opcode != OP_LDW) begin
                    s_ovf = ex_overflow; s_err = ex_error;
                end
            end else if (ex_opcode == OP_LDW || ex_opcode == OP_STR) begin
                m_busy = 1; m_age = 0; m_req = 1;
                m_is_load = (ex_opcode == OP_LDW);
                m_we = !m_is_load;
                m_dest = ex_dest;
                m_addr = m_is_load ? {28'd0, ex_r_a} : {28'd0, ex_dest};
                if (!m_is_load) m_wdata = ex_data;
            end
            m_ovf  = s_ovf  || (m_ovf  && !clr_flags);
            m_err  = s_err  || (m_err  && !clr_flags);
            m_merr = s_merr || (m_merr && !clr_flags);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_stall",   {31'd0, stall},    {31'd0, m_busy});
            chk("cyc_req",     {31'd0, dmem_req}, {31'd0, m_req});
            if (m_req) begin
                chk("cyc_we",    {31'd0, dmem_we},            {31'd0, m_we});
                chk("cyc_addr",  {27'd0, dmem_addr},          m_addr);
                if (m_we) chk("cyc_wdata", dmem_wdata,         m_wdata);
            end
            chk("cyc_wb_en",   {31'd0, wb_en},    {31'd0, m_wb_en});
            chk("cyc_wb_addr", {28'd0, wb_addr},  {28'd0, m_wb_addr});
            chk("cyc_wb_data", wb_data,           m_wb_data);
            chk("cyc_fwd_v",   {31'd0, fwd_valid},{31'd0, m_wb_en});
            chk("cyc_fwd_a",   {28'd0, fwd_addr}, {28'd0, m_wb_addr});
            chk("cyc_fwd_d",   fwd_data,          m_wb_data);
            chk("cyc_ovf",     {31'd0, ovf_flag}, {31'd0, m_ovf});
            chk("cyc_err",     {31'd0, err_flag}, {31'd0, m_err});
            chk("cyc_memerr",  {31'd0, mem_err},  {31'd0, m_merr});
            chk("cyc_retired", {16'd0, retired},  {16'd0, m_ret});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [3:0] dest, input logic [3:0] ra,
                         input logic [31:0] data, input logic isimm, input logic ovf,
                         input logic err, input logic clr);
        ex_opcode = op; ex_dest = dest; ex_r_a = ra; ex_data = data;
        ex_isimm = isimm; ex_overflow = ovf; ex_error = err; clr_flags = clr;
    endtask

    task automatic idle_in();
        drive(OP_NOP, 4'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    int n;

    initial begin
        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        idle_in();
        step();
        cmp_on = 1'b1;
        step();
        chk("rst_req",     {31'd0, dmem_req}, 32'd0);
        chk("rst_wb_en",   {31'd0, wb_en},    32'd0);
        chk("rst_retired", {16'd0, retired},  32'd0);
        chk("rst_stall",   {31'd0, stall},    32'd0);
        rst = 1'b0;

        // ALU add
        drive(OP_ADD, 4'd3, 4'd0, 32'd42, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        idle_in();
        chk("alu_wb_en",   {31'd0, wb_en},    32'd1);
        chk("alu_wb_addr", {28'd0, wb_addr},  32'd3);
        chk("alu_wb_data", wb_data,           32'd42);
        chk("alu_fwd",     fwd_data,          32'd42);
        chk("alu_retired", {16'd0, retired},  32'd1);
        step();
        chk("alu_pulse",   {31'd0, wb_en},    32'd0);
        chk("alu_hold",    {28'd0, wb_addr},  32'd3);

        // LDW from memory, ack three cycles after req
        drive(OP_LDW, 4'd2, 4'd7, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        idle_in();
        chk("ldw_addr", {27'd0, dmem_addr}, 32'd7);
        chk("ldw_we",   {31'd0, dmem_we},   32'd0);
        n = stall ? 1 : 0;
        step();
        n += stall ? 1 : 0;
        step();
        n += stall ? 1 : 0;
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        step();
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        chk("ldw_stall_cycles", n, 32'd3);
        chk("ldw_wb_addr", {28'd0, wb_addr}, 32'd2);
        chk("ldw_wb_data", wb_data,          32'hDEADBEEF);
        chk("ldw_retired", {16'd0, retired}, 32'd2);
        chk("ldw_req_low", {31'd0, dmem_req},32'd0);

        // STR followed at once by an ALU op held under stall
        drive(OP_STR, 4'd9, 4'd0, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(OP_SUB, 4'd5, 4'd0, 32'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("str_we",    {31'd0, dmem_we},   32'd1);
        chk("str_addr",  {27'd0, dmem_addr}, 32'd9);
        chk("str_wdata", dmem_wdata,         32'h55);
        step();
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("str_no_wb",   {31'd0, wb_en},    32'd0);
        chk("str_retired", {16'd0, retired},  32'd3);
        step();
        idle_in();
        chk("b2b_wb_en",   {31'd0, wb_en},    32'd1);
        chk("b2b_wb_data", wb_data,           32'h77);
        chk("b2b_retired", {16'd0, retired},  32'd4);

        // LDW immediate, branch, unknown opcode, ack while idle
        drive(OP_LDW, 4'd6, 4'd1, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("ldi_req",     {31'd0, dmem_req}, 32'd0);
        chk("ldi_wb_data", wb_data,           32'h1234);
        drive(OP_BRQ, 4'd4, 4'd0, 32'h9, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(OP_BAD, 4'd4, 4'd0, 32'h9, 1'b0, 1'b0, 1'b0, 1'b0);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        idle_in();
        chk("nop_retired", {16'd0, retired}, 32'd5);

        // Timeout, then clear
        drive(OP_LDW, 4'd1, 4'd4, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        idle_in();
        n = 0;
        while (dmem_req && n < 40) begin
            step();
            n++;
        end
        chk("to_cycles",  n,                  TIMEOUT);
        chk("to_mem_err", {31'd0, mem_err},   32'd1);
        chk("to_retired", {16'd0, retired},   32'd5);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        chk("to_clear",   {31'd0, mem_err},   32'd0);

        // Ack on the timeout edge completes the load
        drive(OP_LDW, 4'd11, 4'd12, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        idle_in();
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE0001;
        step();
        dmem_ack = 1'b0;
        chk("edge_wb_en",   {31'd0, wb_en},   32'd1);
        chk("edge_wb_data", wb_data,          32'hCAFE0001);
        chk("edge_memerr",  {31'd0, mem_err}, 32'd0);

        // Sticky flags: set beats clear on the same edge
        drive(OP_ADD, 4'd1, 4'd0, 32'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk("ovf_set", {31'd0, ovf_flag}, 32'd1);
        drive(OP_ADD, 4'd1, 4'd0, 32'd2, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        chk("ovf_set_wins", {31'd0, ovf_flag}, 32'd1);
        drive(OP_NOP, 4'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk("ovf_cleared", {31'd0, ovf_flag}, 32'd0);
        drive(OP_CMP, 4'd2, 4'd0, 32'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk("cmp_no_err", {31'd0, err_flag}, 32'd0);
        drive(OP_ADD, 4'd2, 4'd0, 32'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        idle_in();
        chk("err_set", {31'd0, err_flag}, 32'd1);

        // Reset in the second cycle of a load wait, then a late ack
        drive(OP_LDW, 4'd8, 4'd3, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        idle_in();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_req",     {31'd0, dmem_req}, 32'd0);
        chk("mrst_stall",   {31'd0, stall},    32'd0);
        chk("mrst_retired", {16'd0, retired},  32'd0);
        chk("mrst_err",     {31'd0, err_flag}, 32'd0);
        dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
        step();
        dmem_ack = 1'b0;
        chk("late_ack_wb", {31'd0, wb_en},   32'd0);
        chk("late_ack_wd", wb_data,          32'd0);

        // Retire counter wrap
        drive(OP_ADD, 4'd7, 4'd0, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65535; i++) step();
        chk("wrap_max", {16'd0, retired}, 32'h0000FFFF);
        step();
        idle_in();
        chk("wrap_zero", {16'd0, retired}, 32'd0);

        step();
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
